// File: rtl/lsu_pkg.sv
// Shared definitions for the load sequencer: RV32I load encodings, FSM states,
// and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LO,
        S_WAIT_LO,
        S_REQ_HI,
        S_WAIT_HI,
        S_RESP
    } state_e;

    function automatic logic is_legal_ld(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic [2:0] ld_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return 3'd1;
            F3_LH, F3_LHU: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_sequencer_if.sv
// Word-read memory port: req/gnt address phase, rvalid data phase.
interface lsu_load_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_load_sequencer_ld_extract.sv
// Byte-lane alignment and sign/zero extension of a two-word load window.
module ld_extract
    import lsu_pkg::*;
(
    input  logic [63:0] buf_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;
    assign sh = 32'(buf_i >> {off_i, 3'b000});

    always_comb begin
        data_o = '0;
        case (func3_i)
            F3_LB:   data_o = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   data_o = {{16{sh[15]}}, sh[15:0]};
            F3_LW:   data_o = sh;
            F3_LBU:  data_o = {24'b0, sh[7:0]};
            F3_LHU:  data_o = {16'b0, sh[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_load_sequencer.sv
// RV32I load sequencer: one or two word reads per load, then align and extend.
//  state   | meaning
//  IDLE    | waiting for ld_start
//  REQ_LO  | mem_req for the low (or only) word
//  WAIT_LO | waiting for rvalid of the low word
//  REQ_HI  | mem_req for the next word of a split load
//  WAIT_HI | waiting for rvalid of the high word
//  RESP    | ld_done pulse, result registered
module lsu_load_sequencer
    import lsu_pkg::*;
#(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic [2:0]            func3,
    input  logic [31:0]           addr,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [31:0]           ld_data_out,
    output logic                  ld_err,
    lsu_load_sequencer_if.master  mem
);

    localparam int              CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0]   TO_LOAD = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_e        state_q, state_d;
    logic [2:0]    func3_q, func3_d;
    logic [31:0]   addr_q, addr_d;
    logic          split_q, split_d;
    logic [31:0]   lo_q, lo_d, hi_q, hi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic          split_in, tc;
    logic [31:0]   ext_data, lo_addr, hi_addr;

    assign split_in = ({2'b00, addr[1:0]} + {1'b0, ld_size(func3)}) > 4'd4;
    assign tc       = TO_EN && (cnt_q == '0);
    assign lo_addr  = {addr_q[31:2], 2'b00};
    assign hi_addr  = {addr_q[31:2] + 30'd1, 2'b00};

    // Extraction sees the word arriving this cycle so the result is registered with ld_done.
    ld_extract u_ld_extract (
        .buf_i   ({hi_d, lo_d}),
        .off_i   (addr_q[1:0]),
        .func3_i (func3_q),
        .data_o  (ext_data)
    );

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (state_q == S_IDLE && ld_start) begin
            lo_d = '0;
            hi_d = '0;
        end
        if (state_q == S_WAIT_LO && mem.mem_rvalid) lo_d = mem.mem_rdata;
        if (state_q == S_WAIT_HI && mem.mem_rvalid) hi_d = mem.mem_rdata;
    end

    always_comb begin
        state_d = state_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        split_d = split_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    func3_d = func3;
                    addr_d  = addr;
                    split_d = split_in;
                    if (!is_legal_ld(func3) || (split_in && !ALLOW_MISALIGNED)) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d = S_REQ_LO;
                        cnt_d   = TO_LOAD;
                    end
                end
            end
            S_REQ_LO, S_REQ_HI: begin
                if (mem.mem_gnt) begin
                    state_d = (state_q == S_REQ_LO) ? S_WAIT_LO : S_WAIT_HI;
                    cnt_d   = TO_LOAD;
                end else if (tc) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    data_d  = '0;
                end
            end
            S_WAIT_LO, S_WAIT_HI: begin
                if (mem.mem_rvalid) begin
                    if (state_q == S_WAIT_LO && split_q) begin
                        state_d = S_REQ_HI;
                        cnt_d   = TO_LOAD;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        data_d  = ext_data;
                    end
                end else if (tc) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    data_d  = '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            func3_q <= '0;
            addr_q  <= '0;
            split_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            split_q <= split_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign ld_busy      = (state_q != S_IDLE);
    assign ld_done      = (state_q == S_RESP);
    assign ld_data_out  = data_q;
    assign ld_err       = err_q;
    assign mem.mem_req  = (state_q == S_REQ_LO) || (state_q == S_REQ_HI);
    assign mem.mem_addr = (state_q == S_REQ_LO) ? lo_addr :
                          (state_q == S_REQ_HI) ? hi_addr : '0;

endmodule

// File: tb/tb_lsu_load_sequencer.sv
// Directed bench for lsu_load_sequencer: three instances cover the default,
// no-misalign and timeout configurations behind one shared memory driver.
module tb_lsu_load_sequencer;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ld_start;
    logic [2:0]  func3;
    logic [31:0] addr;
    int          sel;
    logic        gnt, rvalid;
    logic [31:0] rdata;

    lsu_load_sequencer_if m_if ();
    lsu_load_sequencer_if n_if ();
    lsu_load_sequencer_if t_if ();

    assign m_if.mem_gnt = gnt; assign m_if.mem_rvalid = rvalid; assign m_if.mem_rdata = rdata;
    assign n_if.mem_gnt = gnt; assign n_if.mem_rvalid = rvalid; assign n_if.mem_rdata = rdata;
    assign t_if.mem_gnt = gnt; assign t_if.mem_rvalid = rvalid; assign t_if.mem_rdata = rdata;

    logic        busy_m, done_m, err_m, busy_n, done_n, err_n, busy_t, done_t, err_t;
    logic [31:0] data_m, data_n, data_t;

    lsu_load_sequencer #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start && (sel == 0)), .func3(func3), .addr(addr),
        .ld_busy(busy_m), .ld_done(done_m), .ld_data_out(data_m), .ld_err(err_m), .mem(m_if));
    lsu_load_sequencer #(.ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start && (sel == 1)), .func3(func3), .addr(addr),
        .ld_busy(busy_n), .ld_done(done_n), .ld_data_out(data_n), .ld_err(err_n), .mem(n_if));
    lsu_load_sequencer #(.ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start && (sel == 2)), .func3(func3), .addr(addr),
        .ld_busy(busy_t), .ld_done(done_t), .ld_data_out(data_t), .ld_err(err_t), .mem(t_if));

    logic        o_busy, o_done, o_err, o_req;
    logic [31:0] o_data, o_addr;
    always_comb begin
        o_busy = busy_m; o_done = done_m; o_err = err_m; o_data = data_m;
        o_req  = m_if.mem_req; o_addr = m_if.mem_addr;
        if (sel == 1) begin
            o_busy = busy_n; o_done = done_n; o_err = err_n; o_data = data_n;
            o_req  = n_if.mem_req; o_addr = n_if.mem_addr;
        end else if (sel == 2) begin
            o_busy = busy_t; o_done = done_t; o_err = err_t; o_data = data_t;
            o_req  = t_if.mem_req; o_addr = t_if.mem_addr;
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int          r_lat, r_nreq;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] r_addr [2];
    bit          r_req_seen, r_addr_moved, r_busy_bad;

    // Issues one load and plays a memory that grants after gnt_wait stall cycles
    // and returns data the cycle after each grant.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w0,
                           input logic [31:0] w1, input int gnt_wait, input bit give_rvalid,
                           input int extra_start_cyc);
        bit          rv_pend = 0, hold_valid = 0;
        int          beat = 0, stall = 0;
        logic [31:0] held = '0;
        r_lat = -1; r_nreq = 0; r_req_seen = 0; r_addr_moved = 0; r_busy_bad = 0;
        r_data = 'x; r_err = 1'bx; r_addr[0] = 'x; r_addr[1] = 'x;
        @(negedge clk);
        ld_start = 1'b1; func3 = f3; addr = a;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            ld_start = (c == extra_start_cyc);
            func3 = F3_LB; addr = 32'h0000_0500;
            gnt = 1'b0; rvalid = 1'b0;
            if (!o_busy) r_busy_bad = 1;
            if (o_done) begin
                r_lat = c; r_data = o_data; r_err = o_err;
                break;
            end
            if (rv_pend) begin
                rvalid = give_rvalid; rdata = (beat == 0) ? w0 : w1;
                beat++; rv_pend = 0;
            end else if (o_req) begin
                r_req_seen = 1;
                if (hold_valid && o_addr !== held) r_addr_moved = 1;
                held = o_addr; hold_valid = 1;
                if (stall < gnt_wait) stall++;
                else begin
                    gnt = 1'b1;
                    if (r_nreq < 2) r_addr[r_nreq] = o_addr;
                    r_nreq++; rv_pend = 1; stall = 0; hold_valid = 0;
                end
            end
        end
        ld_start = 1'b0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (busy_m !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_m); else pass_cnt++;
        chk_cnt++; if (done_m !== 1'b0) $display("FAIL reset_done got %b want 0", done_m); else pass_cnt++;
        chk_cnt++; if (data_m !== 32'h0) $display("FAIL reset_data got %h want 0", data_m); else pass_cnt++;
        chk_cnt++; if (err_m !== 1'b0) $display("FAIL reset_err got %b want 0", err_m); else pass_cnt++;
        chk_cnt++; if (m_if.mem_req !== 1'b0 || m_if.mem_addr !== 32'h0)
            $display("FAIL reset_mem got req=%b addr=%h want 0/0", m_if.mem_req, m_if.mem_addr); else pass_cnt++;
    endtask

    task automatic test_lb_aligned();
        sel = 0;
        do_load(F3_LB, 32'h0000_0103, 32'h80FF_1234, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_data !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want ffffff80", r_data); else pass_cnt++;
        chk_cnt++; if (r_err !== 1'b0) $display("FAIL lb_err got %b want 0", r_err); else pass_cnt++;
        chk_cnt++; if (r_lat !== 3) $display("FAIL lb_latency got %0d want 3", r_lat); else pass_cnt++;
        chk_cnt++; if (r_nreq !== 1 || r_addr[0] !== 32'h100)
            $display("FAIL lb_reads got n=%0d a0=%h want 1/00000100", r_nreq, r_addr[0]); else pass_cnt++;
        chk_cnt++; if (r_busy_bad) $display("FAIL lb_busy got low want high through done"); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (busy_m !== 1'b0 || data_m !== 32'hFFFF_FF80)
            $display("FAIL lb_hold got busy=%b data=%h want 0/ffffff80", busy_m, data_m); else pass_cnt++;
    endtask

    task automatic test_split();
        sel = 0;
        do_load(F3_LHU, 32'h0000_0103, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 0);
        chk_cnt++; if (r_data !== 32'h0000_44AA) $display("FAIL lhu_split_data got %h want 000044aa", r_data); else pass_cnt++;
        chk_cnt++; if (r_lat !== 5) $display("FAIL lhu_split_latency got %0d want 5", r_lat); else pass_cnt++;
        chk_cnt++; if (r_nreq !== 2 || r_addr[0] !== 32'h100 || r_addr[1] !== 32'h104)
            $display("FAIL lhu_split_addr got n=%0d %h %h want 2 00000100 00000104", r_nreq, r_addr[0], r_addr[1]); else pass_cnt++;
        do_load(F3_LW, 32'hFFFF_FFFE, 32'h1122_3344, 32'h5566_7788, 0, 1, 0);
        chk_cnt++; if (r_data !== 32'h7788_1122 || r_err !== 1'b0)
            $display("FAIL lw_wrap_data got %h err=%b want 77881122 0", r_data, r_err); else pass_cnt++;
        chk_cnt++; if (r_addr[0] !== 32'hFFFF_FFFC || r_addr[1] !== 32'h0)
            $display("FAIL lw_wrap_addr got %h %h want fffffffc 00000000", r_addr[0], r_addr[1]); else pass_cnt++;
    endtask

    task automatic test_extend();
        logic [2:0]  f3s [7] = '{F3_LH, F3_LBU, F3_LW, F3_LH, F3_LH, F3_LB, F3_LW};
        logic [31:0] as  [7] = '{32'h2, 32'h1, 32'h10, 32'h1, 32'h3, 32'h2, 32'h101};
        logic [31:0] w0s [7] = '{32'h8001_1234, 32'h0000_9A00, 32'hDEAD_BEEF, 32'h00AB_CD00,
                                 32'hFE00_0000, 32'h007F_0000, 32'h4433_2211};
        logic [31:0] w1s [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0, 32'h0000_0055};
        logic [31:0] exs [7] = '{32'hFFFF_8001, 32'h0000_009A, 32'hDEAD_BEEF, 32'hFFFF_ABCD,
                                 32'hFFFF_FFFE, 32'h0000_007F, 32'h5544_3322};
        int          lats[7] = '{3, 3, 3, 3, 5, 3, 5};
        sel = 0;
        for (int i = 0; i < 7; i++) begin
            do_load(f3s[i], as[i], w0s[i], w1s[i], 0, 1, 0);
            chk_cnt++; if (r_data !== exs[i] || r_err !== 1'b0 || r_lat !== lats[i])
                $display("FAIL extend_%0d got data=%h err=%b lat=%0d want %h 0 %0d",
                         i, r_data, r_err, r_lat, exs[i], lats[i]); else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        sel = 0;
        do_load(3'b011, 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0)
            $display("FAIL illegal_f3 got lat=%0d err=%b data=%h want 1 1 0", r_lat, r_err, r_data); else pass_cnt++;
        chk_cnt++; if (r_req_seen) $display("FAIL illegal_f3_req got mem_req=1 want never"); else pass_cnt++;
        do_load(3'b111, 32'h0000_0100, 32'h1234_5678, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_lat !== 1 || r_err !== 1'b1)
            $display("FAIL illegal_f3_111 got lat=%0d err=%b want 1 1", r_lat, r_err); else pass_cnt++;
        sel = 1;
        do_load(F3_LW, 32'h0000_0002, 32'h1234_5678, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_lat !== 1 || r_err !== 1'b1 || r_data !== 32'h0 || r_req_seen)
            $display("FAIL nomis_lw got lat=%0d err=%b data=%h req=%b want 1 1 0 0",
                     r_lat, r_err, r_data, r_req_seen); else pass_cnt++;
        do_load(F3_LH, 32'h0000_0002, 32'h8001_1234, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_lat !== 3 || r_err !== 1'b0 || r_data !== 32'hFFFF_8001)
            $display("FAIL nomis_lh got lat=%0d err=%b data=%h want 3 0 ffff8001", r_lat, r_err, r_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int extra_done = 0, extra_req = 0;
        sel = 0;
        do_load(F3_LW, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5, 1, 2);
        chk_cnt++; if (r_addr_moved || r_addr[0] !== 32'h300)
            $display("FAIL stall_addr got moved=%b a0=%h want 0 00000300", r_addr_moved, r_addr[0]); else pass_cnt++;
        chk_cnt++; if (r_lat !== 8 || r_data !== 32'hCAFE_F00D || r_nreq !== 1)
            $display("FAIL stall_result got lat=%0d data=%h n=%0d want 8 cafef00d 1", r_lat, r_data, r_nreq); else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_done) extra_done++;
            if (o_req) extra_req++;
        end
        chk_cnt++; if (extra_done != 0 || extra_req != 0)
            $display("FAIL dropped_start got done=%0d req=%0d want 0 0", extra_done, extra_req); else pass_cnt++;
        do_load(F3_LBU, 32'h0000_0007, 32'hF000_0000, 32'h0, 0, 1, 0);
        do_load(F3_LB,  32'h0000_0007, 32'h8100_0000, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_data !== 32'hFFFF_FF81 || r_lat !== 3)
            $display("FAIL back_to_back got data=%h lat=%0d want ffffff81 3", r_data, r_lat); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        sel = 0;
        @(negedge clk); ld_start = 1'b1; func3 = F3_LW; addr = 32'h0000_0040;
        @(negedge clk); ld_start = 1'b0; gnt = 1'b1;
        @(negedge clk); gnt = 1'b0;
        chk_cnt++; if (!busy_m || m_if.mem_req !== 1'b0)
            $display("FAIL pre_reset_state got busy=%b req=%b want 1 0", busy_m, m_if.mem_req); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (m_if.mem_req !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 ||
                       data_m !== 32'h0 || err_m !== 1'b0)
            $display("FAIL reset_mid got req=%b busy=%b done=%b data=%h err=%b want all 0",
                     m_if.mem_req, busy_m, done_m, data_m, err_m); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
        @(negedge clk); rvalid = 1'b0;
        chk_cnt++; if (busy_m !== 1'b0 || done_m !== 1'b0 || data_m !== 32'h0)
            $display("FAIL stale_rvalid got busy=%b done=%b data=%h want 0 0 0", busy_m, done_m, data_m); else pass_cnt++;
        do_load(F3_LW, 32'h0000_0044, 32'h1357_9BDF, 32'h0, 0, 1, 0);
        chk_cnt++; if (r_data !== 32'h1357_9BDF || r_lat !== 3 || r_err !== 1'b0)
            $display("FAIL after_reset_lw got data=%h lat=%0d err=%b want 13579bdf 3 0", r_data, r_lat, r_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        sel = 2;
        do_load(F3_LW, 32'h0000_0040, 32'h1111_2222, 32'h0, 0, 0, 0);
        chk_cnt++; if (r_lat !== 6 || r_err !== 1'b1 || r_data !== 32'h0)
            $display("FAIL rvalid_timeout got lat=%0d err=%b data=%h want 6 1 0", r_lat, r_err, r_data); else pass_cnt++;
        @(negedge clk); rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk); rvalid = 1'b0;
        chk_cnt++; if (busy_t !== 1'b0 || done_t !== 1'b0)
            $display("FAIL late_rvalid got busy=%b done=%b want 0 0", busy_t, done_t); else pass_cnt++;
        do_load(F3_LW, 32'h0000_0080, 32'h1111_2222, 32'h0, 100, 1, 0);
        chk_cnt++; if (r_lat !== 5 || r_err !== 1'b1 || t_if.mem_req !== 1'b0)
            $display("FAIL gnt_timeout got lat=%0d err=%b req=%b want 5 1 0", r_lat, r_err, t_if.mem_req); else pass_cnt++;
        do_load(F3_LH, 32'h0000_0003, 32'h9900_0000, 32'h0000_0088, 0, 1, 0);
        chk_cnt++; if (r_lat !== 5 || r_err !== 1'b0 || r_data !== 32'hFFFF_8899)
            $display("FAIL timeout_cfg_split got lat=%0d err=%b data=%h want 5 0 ffff8899", r_lat, r_err, r_data); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; ld_start = 1'b0; func3 = '0; addr = '0; sel = 0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_lb_aligned();
        test_split();
        test_extend();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
